// File: rtl/button_debouncer.sv
// Pushbutton conditioner: synchroniser, debounce FSM, press/release strobes and a wrapping press counter.
// Optional long-press strobe is built only when BUTTON_DEBOUNCER_LONG_EN is defined.
module button_debouncer #(
   parameter int unsigned CLK_HZ      = 12000000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000,
   parameter bit          ACTIVE_LOW  = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN,
   output logic       PRESSED,
   output logic       PRESS,
   output logic       RELEASE,
   output logic       LONG,
   output logic [7:0] COUNT
);

   localparam int unsigned DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
   localparam int unsigned DB_W        = $clog2(DB_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   if (DB_CYCLES == 0) begin : g_bad_debounce
      $error("button_debouncer: DEBOUNCE_MS too short for CLK_HZ, DB_CYCLES must be >= 1");
   end
   if (LONG_CYCLES > 32'h7FFF_FFFF) begin : g_bad_long
      $error("button_debouncer: LONG_MS too large for CLK_HZ");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM_DN = 2'd1,
      DOWN   = 2'd2,
      ARM_UP = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [DB_W-1:0] dc, dc_nxt;
   logic            act;
   logic            sync_q1;
   logic            s;
   logic            pressed_c, press_c, release_c;

   // Polarity is folded in ahead of the synchroniser so everything downstream is active-high.
   assign act = BTN ^ ACTIVE_LOW;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q1 <= 1'b0;
         s       <= 1'b0;
      end else begin
         sync_q1 <= act;
         s       <= sync_q1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         dc    <= '0;
      end else begin
         state <= state_nxt;
         dc    <= dc_nxt;
      end
   end

   // Debounce counter only advances while arming and is wiped on every state change.
   always_comb begin
      state_nxt = state;
      dc_nxt    = dc;
      case (state)
         IDLE: begin
            if (s) state_nxt = ARM_DN;
         end
         ARM_DN: begin
            if (!s)                state_nxt = IDLE;
            else if (dc == DB_LAST) state_nxt = DOWN;
            else                    dc_nxt    = dc + DB_W'(1);
         end
         DOWN: begin
            if (!s) state_nxt = ARM_UP;
         end
         ARM_UP: begin
            if (s)                  state_nxt = DOWN;
            else if (dc == DB_LAST) state_nxt = IDLE;
            else                    dc_nxt    = dc + DB_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) dc_nxt = '0;
   end

   // Output decode uses the next state so the registered outputs line up with the state register.
   always_comb begin
      pressed_c = 1'b0;
      press_c   = 1'b0;
      release_c = 1'b0;
      if (state_nxt == DOWN || state_nxt == ARM_UP) pressed_c = 1'b1;
      if (state == ARM_DN && state_nxt == DOWN)     press_c   = 1'b1;
      if (state == ARM_UP && state_nxt == IDLE)     release_c = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         PRESSED <= 1'b0;
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
         COUNT   <= 8'd0;
      end else begin
         PRESSED <= pressed_c;
         PRESS   <= press_c;
         RELEASE <= release_c;
         COUNT   <= COUNT + 8'(PRESS);
      end
   end

`ifdef BUTTON_DEBOUNCER_LONG_EN
   localparam int unsigned HC_W = $clog2(LONG_CYCLES) + 1;
   localparam logic [HC_W-1:0] HC_MAX  = HC_W'(LONG_CYCLES);
   localparam logic [HC_W-1:0] HC_FIRE = HC_W'(LONG_CYCLES - 1);

   logic [HC_W-1:0] hc;
   logic            held;
   logic            long_c;

   assign held = (state == DOWN) || (state == ARM_UP);

   // Hold counter restarts only on a fresh press, so a bounce while held cannot re-arm LONG.
   always_ff @(posedge CLK) begin
      if (RST) begin
         hc <= '0;
      end else if (press_c) begin
         hc <= '0;
      end else if (held && hc != HC_MAX) begin
         hc <= hc + HC_W'(1);
      end
   end

   always_comb begin
      long_c = 1'b0;
      if (LONG_CYCLES != 0 && held && hc == HC_FIRE && state_nxt != IDLE) long_c = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) LONG <= 1'b0;
      else     LONG <= long_c;
   end
`else
   assign LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed testbench for button_debouncer with DB_CYCLES=4, LONG_CYCLES=10.
// Long-press expectations follow BUTTON_DEBOUNCER_LONG_EN.
module tb_button_debouncer;

   logic       CLK;
   logic       RST;
   logic       BTN;
   logic       PRESSED;
   logic       PRESS;
   logic       RELEASE;
   logic       LONG;
   logic [7:0] COUNT;

   int n_checks = 0;
   int n_fail   = 0;
   int n_press  = 0;
   int n_rel    = 0;

   button_debouncer #(
      .CLK_HZ     (1000),
      .DEBOUNCE_MS(4),
      .LONG_MS    (10),
      .ACTIVE_LOW (1'b0)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .BTN    (BTN),
      .PRESSED(PRESSED),
      .PRESS  (PRESS),
      .RELEASE(RELEASE),
      .LONG   (LONG),
      .COUNT  (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One rising edge; outputs are observed 1 time unit later and strobes are tallied.
   task automatic step();
      @(posedge CLK);
      #1;
      if (PRESS === 1'b1)   n_press++;
      if (RELEASE === 1'b1) n_rel++;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      BTN = 1'b0;
      step();
      step();
      n_checks++;
      if ({PRESSED, PRESS, RELEASE, LONG} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b exp=0000", {PRESSED, PRESS, RELEASE, LONG});
      end
      n_checks++;
      if (COUNT !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_count got=%0d exp=0", COUNT);
      end
   endtask

   task automatic test_clean_press();
      logic [2:0] exp;
      logic [7:0] exp_cnt;
      RST = 1'b1;
      BTN = 1'b0;
      for (int e = 1; e <= 2; e++) step();
      RST = 1'b0;
      for (int e = 3; e <= 9; e++) step();
      BTN = 1'b1;
      for (int e = 10; e <= 20; e++) begin
         step();
         exp     = {e >= 16, e == 16, 1'b0};
         exp_cnt = (e >= 17) ? 8'd1 : 8'd0;
         n_checks++;
         if ({PRESSED, PRESS, RELEASE} !== exp) begin
            n_fail++;
            $display("FAIL clean_press edge=%0d got=%b exp=%b", e, {PRESSED, PRESS, RELEASE}, exp);
         end
         n_checks++;
         if (COUNT !== exp_cnt) begin
            n_fail++;
            $display("FAIL clean_press_count edge=%0d got=%0d exp=%0d", e, COUNT, exp_cnt);
         end
      end
   endtask

   task automatic test_release();
      logic [2:0] exp;
      BTN = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp = {k < 7, 1'b0, k == 7};
         n_checks++;
         if ({PRESSED, PRESS, RELEASE} !== exp || COUNT !== 8'd1) begin
            n_fail++;
            $display("FAIL release k=%0d got=%b cnt=%0d exp=%b cnt=1", k, {PRESSED, PRESS, RELEASE}, COUNT, exp);
         end
      end
   endtask

   task automatic test_glitch();
      // Short 3-sample pulse from idle.
      BTN = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         if (k == 4) BTN = 1'b0;
         step();
         n_checks++;
         if ({PRESSED, PRESS, RELEASE} !== 3'b000 || COUNT !== 8'd1) begin
            n_fail++;
            $display("FAIL glitch_idle k=%0d got=%b cnt=%0d exp=000 cnt=1", k, {PRESSED, PRESS, RELEASE}, COUNT);
         end
      end
      BTN = 1'b1;
      for (int k = 1; k <= 10; k++) step();
      n_checks++;
      if (PRESSED !== 1'b1 || COUNT !== 8'd2) begin
         n_fail++;
         $display("FAIL glitch_setup got pressed=%b cnt=%0d exp pressed=1 cnt=2", PRESSED, COUNT);
      end
      // 2-sample dip while held.
      BTN = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         if (k == 3) BTN = 1'b1;
         step();
         n_checks++;
         if ({PRESSED, PRESS, RELEASE} !== 3'b100 || COUNT !== 8'd2) begin
            n_fail++;
            $display("FAIL glitch_dip k=%0d got=%b cnt=%0d exp=100 cnt=2", k, {PRESSED, PRESS, RELEASE}, COUNT);
         end
      end
      BTN = 1'b0;
      for (int k = 1; k <= 10; k++) step();
   endtask

   task automatic test_wrap();
      int p0;
      int r0;
      RST = 1'b1;
      BTN = 1'b0;
      step();
      step();
      RST = 1'b0;
      p0 = n_press;
      r0 = n_rel;
      for (int i = 0; i < 256; i++) begin
         BTN = 1'b1;
         for (int k = 0; k < 8; k++) step();
         if (i == 254) begin
            n_checks++;
            if (COUNT !== 8'd255) begin
               n_fail++;
               $display("FAIL wrap_255 got=%0d exp=255", COUNT);
            end
         end
         if (i == 255) begin
            n_checks++;
            if (COUNT !== 8'd0) begin
               n_fail++;
               $display("FAIL wrap_0 got=%0d exp=0", COUNT);
            end
         end
         BTN = 1'b0;
         for (int k = 0; k < 8; k++) step();
      end
      n_checks++;
      if (n_press - p0 != 256) begin
         n_fail++;
         $display("FAIL wrap_press_pulses got=%0d exp=256", n_press - p0);
      end
      n_checks++;
      if (n_rel - r0 != 256) begin
         n_fail++;
         $display("FAIL wrap_release_pulses got=%0d exp=256", n_rel - r0);
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] exp;
      logic [7:0] exp_cnt;
      BTN = 1'b1;
      for (int k = 1; k <= 10; k++) step();
      BTN = 1'b0;
      for (int k = 1; k <= 10; k++) step();
      n_checks++;
      if (COUNT !== 8'd1) begin
         n_fail++;
         $display("FAIL reset_mid_setup got=%0d exp=1", COUNT);
      end
      BTN = 1'b1;
      for (int k = 1; k <= 4; k++) step();
      RST = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_checks++;
         if ({PRESSED, PRESS, RELEASE, LONG} !== 4'b0000 || COUNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold k=%0d got=%b cnt=%0d exp=0000 cnt=0", k, {PRESSED, PRESS, RELEASE, LONG}, COUNT);
         end
      end
      RST = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp     = {k >= 7, k == 7, 1'b0};
         exp_cnt = (k >= 8) ? 8'd1 : 8'd0;
         n_checks++;
         if ({PRESSED, PRESS, RELEASE} !== exp || COUNT !== exp_cnt) begin
            n_fail++;
            $display("FAIL reset_mid k=%0d got=%b cnt=%0d exp=%b cnt=%0d", k, {PRESSED, PRESS, RELEASE}, COUNT, exp, exp_cnt);
         end
      end
      BTN = 1'b0;
      for (int k = 1; k <= 10; k++) step();
   endtask

   task automatic test_long();
      logic exp_long;
      BTN = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
`ifdef BUTTON_DEBOUNCER_LONG_EN
         exp_long = (k == 17);
`else
         exp_long = 1'b0;
`endif
         n_checks++;
         if (LONG !== exp_long || PRESS !== (k == 7)) begin
            n_fail++;
            $display("FAIL long_hold k=%0d got long=%b press=%b exp long=%b press=%b", k, LONG, PRESS, exp_long, k == 7);
         end
      end
      BTN = 1'b0;
      for (int k = 1; k <= 10; k++) step();
      // 7-sample hold: accepted press, released before the long threshold.
      BTN = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         if (k == 8) BTN = 1'b0;
         step();
         n_checks++;
         if ({LONG, PRESS, RELEASE} !== {1'b0, k == 7, k == 14}) begin
            n_fail++;
            $display("FAIL long_short k=%0d got=%b exp=%b", k, {LONG, PRESS, RELEASE}, {1'b0, k == 7, k == 14});
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      BTN = 1'b0;
      test_reset();
      test_clean_press();
      test_release();
      test_glitch();
      test_wrap();
      test_reset_mid();
      test_long();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the LED blinker: samples one raw pushbutton pin, synchronises and debounces it, and emits a clean level, one-cycle press/release events and a wrapping press counter.
- Sits between a board button pin and user logic (e.g. LED drivers on LEDS).
- Timing is expressed in milliseconds and derived from the clock frequency.

Parameters:
- CLK_HZ, 12000000, clock frequency in Hz.
- DEBOUNCE_MS, 20, stable time required before a change is accepted.
- LONG_MS, 1000, hold time for a long-press event (used only with the optional feature).
- ACTIVE_LOW, 0, 1 = BTN reads 0 when pressed.
- Derived values:
  - DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS; must be >= 1, elaboration error otherwise.
  - LONG_CYCLES = CLK_HZ/1000*LONG_MS.
  - Counter widths are $clog2 of these plus 1.

Ports:
- CLK  input  1  system clock (12 MHz on board).
- RST  input  1  synchronous, active-high reset.
- BTN  input  1  raw asynchronous button pin.
- PRESSED  output  1  debounced level, 1 = pressed.
- PRESS  output  1  one-cycle pulse on accepted press.
- RELEASE  output  1  one-cycle pulse on accepted release.
- LONG  output  1  one-cycle long-press pulse (tied 0 without the macro).
- COUNT  output  8  number of accepted presses, modulo 256.

Behaviour:
- Polarity: act = BTN XOR ACTIVE_LOW, taken before synchronisation.
- Synchroniser:
  - 2-FF synchroniser on act; both FFs reset to 0 (inactive).
  - Call its output s.
- FSM states: IDLE, ARM_DN, DOWN, ARM_UP. A debounce counter dc is cleared on every state change.
- IDLE:
  - s=1 -> ARM_DN.
  - else stay.
- ARM_DN:
  - s=0 -> IDLE.
  - else dc++.
  - dc==DB_CYCLES-1 with s=1 -> DOWN.
- DOWN:
  - s=0 -> ARM_UP.
  - else stay.
- ARM_UP:
  - s=1 -> DOWN; this is a glitch and produces no events.
  - else dc++.
  - dc==DB_CYCLES-1 with s=0 -> IDLE.
- All outputs are registered.
- PRESSED:
  - Is 1 exactly in states DOWN and ARM_UP.
  - Rises DB_CYCLES+2 rising edges after the first edge that samples act=1, provided act stays 1 throughout.
- PRESS: asserted for the single cycle in which PRESSED first reads 1 (ARM_DN->DOWN transition).
- RELEASE: asserted for the single cycle in which PRESSED first reads 0 (ARM_UP->IDLE transition).
- Glitches: any act pulse shorter than DB_CYCLES cycles produces no PRESS, RELEASE or COUNT change.
- COUNT:
  - Increments by 1 in the same cycle PRESS asserts (value visible the cycle after).
  - 8-bit wrap: 255 -> 0.
- Reset:
  - Values: state=IDLE, dc=0, sync FFs=0, PRESSED=0, PRESS=0, RELEASE=0, LONG=0, COUNT=0.
  - Reset mid-debounce discards the partial count.
  - A button held through reset release is treated as a new press: PRESS follows DB_CYCLES+2 edges after the first post-reset edge.
- dc never exceeds DB_CYCLES-1.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_LONG_EN.
- Defined:
  - Hold counter hc clears on entry to DOWN and increments each cycle in DOWN or ARM_UP.
  - hc saturates at LONG_CYCLES.
  - LONG pulses one cycle when hc reaches LONG_CYCLES-1. That is exactly LONG_CYCLES cycles after PRESS, and at most once per press.
  - A release accepted earlier cancels the long press.
  - If LONG_CYCLES==0, LONG never asserts.
- Undefined:
  - hc is not instantiated.
  - LONG is constant 0.
  - All other behaviour is identical.

Test Plan (CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10, ACTIVE_LOW=0, so DB_CYCLES=4, LONG_CYCLES=10):
- Clean press:
  - Stimulus: RST 2 cycles; BTN=1 from edge 10.
  - Required: PRESSED rises and PRESS=1 at edge 16 only; COUNT=1 from edge 17; RELEASE stays 0.
- Glitch rejection:
  - Stimulus: BTN=1 for 3 cycles, then 0; later a 2-cycle 0 dip while pressed.
  - Required: no PRESS, no RELEASE, COUNT unchanged; PRESSED stays at its prior level.
- Release:
  - Stimulus: after an accepted press, BTN=0 held.
  - Required: PRESSED falls and RELEASE=1 for exactly one cycle, 6 edges after the first 0 sample; no PRESS.
- Counter wrap: 256 clean press/release pairs -> COUNT=0 after the 256th PRESS, with exactly 256 PRESS pulses counted.
- Reset mid-operation:
  - Stimulus: BTN=1; RST asserted at edge 3 of ARM_DN, released; BTN kept high.
  - Required: all outputs 0 during reset; PRESS 6 edges after the first post-reset edge; COUNT=1.
- Long press, with BUTTON_DEBOUNCER_LONG_EN:
  - Stimulus: BTN held 30 cycles.
  - Required: LONG=1 exactly one cycle, 10 cycles after PRESS.
  - Without the macro: LONG is always 0.
  - A 7-cycle hold yields no LONG.
